multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Sequential controller that computes a WIDTH-bit sum by time-multiplexing one shared 2-bit add slice (A+B+Cin producing a 2-bit sum and a carry-out) over WIDTH/2 cycles, LSB slice first.
- Holds the operands, slice index and inter-slice carry register, and a start/busy/done handshake.
- Used wherever a wide add is needed but area matters more than latency; the 2-bit slice is instantiated inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2.
- CNT_W, $clog2(WIDTH/2)+1, slice counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request a new addition; sampled only when accepted (see Behaviour).
- a  input  WIDTH  operand A; captured on start acceptance.
- b  input  WIDTH  operand B; captured on start acceptance.
- cin  input  1  carry into bit 0; captured on start acceptance.
- busy  output  1  high while slices are being processed (state RUN).
- done  output  1  single-cycle pulse: sum/cout valid and updated.
- sum  output  WIDTH  result bits; held until next completion.
- cout  output  1  carry out of bit WIDTH-1; held with sum.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry register=0, operand/work registers=0. Reset dominates start and any in-flight operation; a reset mid-RUN aborts it with no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Transitions:
  - IDLE, start=1 -> RUN: latch a, b, cin into the carry register; counter=0.
  - IDLE, start=0 -> IDLE.
  - RUN, counter < N-1 (N=WIDTH/2) -> RUN: process slice k=counter, then counter+1.
  - RUN, counter = N-1 -> DONE: process the final slice; copy the work register to sum and the final carry to cout.
  - DONE, start=1 -> RUN: back-to-back operation, latched exactly as from IDLE.
  - DONE, start=0 -> IDLE.
- Slice k (each RUN edge):
  - Slice inputs are a_reg[2k+1:2k], b_reg[2k+1:2k] and the carry register.
  - The slice 2-bit sum is written to work[2k+1:2k].
  - The slice carry-out is written to the carry register.
- Latency: start sampled at edge E0; slices processed at edges E1..EN; done=1 and new sum/cout visible in the cycle after EN. For WIDTH=8, done follows 4 cycles after the start edge. Throughput is one result per N+1 cycles (DONE->RUN path).
- start while busy=1 is ignored: no queuing, and operands are not re-latched.
- Changes on a/b/cin after acceptance have no effect on the in-flight result.
- sum/cout change only at the RUN->DONE edge or at reset; they stay stable through IDLE and through a subsequent RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); overflow is reported solely via cout.
- WIDTH=2 degenerate case: one RUN cycle; done appears in the cycle after E1.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start for 1 cycle -> busy high for 4 cycles, then done pulse 1 cycle; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 (full carry ripple across all slices) -> sum=8'h00, cout=1.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Accept a=8'h10, b=8'h20, then pulse start with a=8'hFF, b=8'hFF during RUN -> ignored; sum=8'h30, cout=0, exactly one done pulse.
- Start a=8'hAA, b=8'h55; assert rst_n=0 at the second RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0; no done afterwards until a new start.
- Hold start=1 continuously with a=8'h01, b=8'h01, cin=1 -> done pulse every 5 cycles, busy low only in DONE cycles, sum=8'h03, cout=0 each time.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Wide adder that reuses one 2-bit add slice over WIDTH/2 cycles, LSB slice first.
// start/busy/done handshake; sum/cout are held until the next completion.

module add2_slice (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci,
   output logic [1:0] s,
   output logic       co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {2'b00, ci};
endmodule

module multiword_add_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int N = WIDTH / 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept, last;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_reg, b_reg, work, work_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             carry;
   logic [1:0]       ss;
   logic             sc;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   assign last = (cnt == CNT_W'(N - 1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            // back-to-back start is accepted straight from DONE
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // current slice operands: bits [2k+1:2k] shifted down to the bottom
   assign a_sh = a_reg >> {cnt, 1'b0};
   assign b_sh = b_reg >> {cnt, 1'b0};

   add2_slice u_slice (
      .a  (a_sh[1:0]),
      .b  (b_sh[1:0]),
      .ci (carry),
      .s  (ss),
      .co (sc)
   );

   always_comb begin
      work_nxt = work;
      for (int k = 0; k < N; k++) begin
         if (cnt == CNT_W'(k)) work_nxt[2*k +: 2] = ss;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         work   <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            work  <= '0;
         end else if (state == RUN) begin
            work  <= work_nxt;
            carry <= sc;
            cnt   <= cnt + 1'b1;
            // final slice: publish the result together with its carry
            if (last) begin
               sum_q  <= work_nxt;
               cout_q <= sc;
            end
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (WIDTH=8) with a cycle-level reference model
// and hand-computed literal expectations.

module tb_multiword_add_seq;
   localparam int W = 8;
   localparam int N = W / 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         cout;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   multiword_add_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an accepted request occupies N cycles, then shows the
   // arithmetic result with a one-cycle done; only idle/done cycles accept start.
   int         m_rem  = 0;
   bit         m_done = 1'b0;
   logic [W:0] m_pend = '0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_done <= 1'b1;
            {m_cout, m_sum} <= m_pend;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            m_pend <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_rem  <= N;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model busy", {31'd0, busy}, {31'd0, m_rem != 0});
         chk("model done", {31'd0, done}, {31'd0, m_done});
         chk("model sum",  {24'd0, sum},  {24'd0, m_sum});
         chk("model cout", {31'd0, cout}, {31'd0, m_cout});
      end
   end

   // single-cycle start; returns after done is seen (or budget expires)
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         output int busy_cyc);
      bit seen;
      busy_cyc = 0;
      seen = 1'b0;
      start = 1'b1; a = ta; b = tb_; cin = tc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cyc++;
         @(negedge clk);
      end
      if (!seen) chk("done timeout", 32'd0, 32'd1);
   endtask

   int bc, ndone, last_i;
   logic [W-1:0] cap_sum;
   logic         cap_cout;

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset sum",  {24'd0, sum},  32'd0);
      chk("reset cout", {31'd0, cout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 5A + 3C = 96
      run_op(8'h5A, 8'h3C, 1'b0, bc);
      chk("t1 busy cycles", bc, 32'd4);
      chk("t1 sum",  {24'd0, sum},  32'h96);
      chk("t1 cout", {31'd0, cout}, 32'd0);
      chk("t1 model sum", {24'd0, m_sum}, 32'h96);
      @(negedge clk);
      chk("t1 idle hold", {24'd0, sum}, 32'h96);

      // full ripple
      run_op(8'hFF, 8'h01, 1'b0, bc);
      chk("t2 sum",  {24'd0, sum},  32'h00);
      chk("t2 cout", {31'd0, cout}, 32'd1);
      @(negedge clk);

      run_op(8'hFF, 8'hFF, 1'b1, bc);
      chk("t3 sum",  {24'd0, sum},  32'hFF);
      chk("t3 cout", {31'd0, cout}, 32'd1);
      @(negedge clk);

      run_op(8'h80, 8'h80, 1'b1, bc);
      chk("t3b sum",  {24'd0, sum},  32'h01);
      chk("t3b cout", {31'd0, cout}, 32'd1);
      @(negedge clk);

      // start during RUN is ignored
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) begin
            ndone++;
            cap_sum = sum;
            cap_cout = cout;
         end
         @(negedge clk);
      end
      chk("t4 done count", ndone, 32'd1);
      chk("t4 sum",  {24'd0, cap_sum},  32'h30);
      chk("t4 cout", {31'd0, cap_cout}, 32'd0);

      // reset in the second RUN cycle aborts
      start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5 busy", {31'd0, busy}, 32'd0);
      chk("t5 done", {31'd0, done}, 32'd0);
      chk("t5 sum",  {24'd0, sum},  32'd0);
      chk("t5 cout", {31'd0, cout}, 32'd0);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("t5 no done", ndone, 32'd0);

      // start held: one result every N+1 cycles
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
      ndone = 0; last_i = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            if (last_i >= 0) chk("t6 period", i - last_i, 32'd5);
            chk("t6 sum",  {24'd0, sum},  32'h03);
            chk("t6 cout", {31'd0, cout}, 32'd0);
            last_i = i;
            ndone++;
         end else begin
            chk("t6 busy", {31'd0, busy}, 32'd1);
         end
      end
      chk("t6 done count", ndone, 32'd4);
      start = 1'b0;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1);
   end

endmodule
